// File: rtl/md_unit_param_if.sv
// rtl/md_unit_param_if.sv - command/result bundle between the E-stage control and the mul/div unit
interface md_unit_param_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       op;
  logic [WIDTH-1:0] dh;
  logic [WIDTH-1:0] dl;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done;
  logic             div_zero;
  logic             invalid;

  modport master (
    output op, dh, dl, cancel,
    input  busy, hi, lo, done, div_zero, invalid
  );

  modport slave (
    input  op, dh, dl, cancel,
    output busy, hi, lo, done, div_zero, invalid
  );
endinterface

// File: rtl/md_unit_param.sv
// rtl/md_unit_param.sv - parametrised multiply/divide/accumulate unit with HI/LO registers
module md_unit_param #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 32
) (
  input logic            clk,
  input logic            rst,
  md_unit_param_if.slave bus
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MUL_N  = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] ITER_N = CW'(WIDTH);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, div_zero_q, invalid_q;
  logic [CW-1:0]      cnt;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               mul_sgn_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic               neg_q, neg_r;

  logic start_mul, start_div, div_by_zero, bad_op, wr_hi, wr_lo, finish;

  // Operand conditioning at acceptance: signedness and divider magnitudes.
  logic             acc_signed_mul, acc_signed_div;
  logic [WIDTH-1:0] abs_dh, abs_dl;
  assign acc_signed_mul = (bus.op == OP_MULT) || (bus.op == OP_MADD) || (bus.op == OP_MSUB);
  assign acc_signed_div = (bus.op == OP_DIV);
  assign abs_dh = (acc_signed_div && bus.dh[WIDTH-1]) ? -bus.dh : bus.dh;
  assign abs_dl = (acc_signed_div && bus.dl[WIDTH-1]) ? -bus.dl : bus.dl;

  // One restoring-division step; an extra guard bit keeps the trial sign unambiguous.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             step_ok, in_iter;
  logic [WIDTH-1:0] rem_step, quo_step, rem_fin, quo_fin, q_out, r_out;
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, dvs_q};
  assign step_ok  = !trial[WIDTH+1];
  assign rem_step = step_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {quo_q[WIDTH-2:0], step_ok};
  assign in_iter  = (cnt <= ITER_N);
  // When DIV_CYCLES == WIDTH the final iteration lands on the write-back edge.
  assign rem_fin  = in_iter ? rem_step : rem_q;
  assign quo_fin  = in_iter ? quo_step : quo_q;
  assign q_out    = neg_q ? -quo_fin : quo_fin;
  assign r_out    = neg_r ? -rem_fin : rem_fin;

  // Full-width product from latched operands; accumulation wraps modulo 2^(2*WIDTH).
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, mul_res;
  assign ext_a = mul_sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b = mul_sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;

  // Select plain product, accumulate or subtract by the latched op.
  always_comb begin
    mul_res = prod;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = acc_q + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc_q - prod;
      default:           mul_res = prod;
    endcase
  end

  // Next-state and one-cycle control strobes; cancel outranks any op.
  always_comb begin
    state_n     = state;
    start_mul   = 1'b0;
    start_div   = 1'b0;
    div_by_zero = 1'b0;
    bad_op      = 1'b0;
    wr_hi       = 1'b0;
    wr_lo       = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.cancel) begin
          case (bus.op)
            OP_NOP: ;
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              start_mul = 1'b1;
              state_n   = MUL;
            end
            OP_DIV, OP_DIVU: begin
              if (bus.dl == '0) begin
                div_by_zero = 1'b1;
              end else begin
                start_div = 1'b1;
                state_n   = DIV;
              end
            end
            OP_MTHI: wr_hi  = 1'b1;
            OP_MTLO: wr_lo  = 1'b1;
            default: bad_op = 1'b1;
          endcase
        end
      end
      MUL: begin
        if (bus.cancel) begin
          state_n = IDLE;
        end else if (cnt == MUL_N) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      DIV: begin
        if (bus.cancel) begin
          state_n = IDLE;
        end else if (cnt == DIV_N) begin
          finish  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath: operand latch, busy counter, divider iterations and HI/LO write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      invalid_q  <= 1'b0;
      cnt        <= '0;
      op_q       <= OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      mul_sgn_q  <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      done_q     <= finish;
      div_zero_q <= div_by_zero;
      invalid_q  <= bad_op;
      if (wr_hi) hi_q <= bus.dh;
      if (wr_lo) lo_q <= bus.dh;
      if (start_mul || start_div) begin
        cnt       <= CW'(1);
        op_q      <= bus.op;
        a_q       <= bus.dh;
        b_q       <= bus.dl;
        acc_q     <= {hi_q, lo_q};
        mul_sgn_q <= acc_signed_mul;
        rem_q     <= '0;
        quo_q     <= abs_dh;
        dvs_q     <= abs_dl;
        neg_q     <= acc_signed_div && (bus.dh[WIDTH-1] ^ bus.dl[WIDTH-1]);
        neg_r     <= acc_signed_div && bus.dh[WIDTH-1];
      end else if (state != IDLE) begin
        if (bus.cancel) begin
          cnt <= '0;
        end else if (finish) begin
          cnt <= '0;
          if (state == MUL) begin
            {hi_q, lo_q} <= mul_res;
          end else begin
            hi_q <= r_out;
            lo_q <= q_out;
          end
        end else begin
          cnt <= cnt + 1'b1;
          if (state == DIV && in_iter) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
          end
        end
      end
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.invalid  = invalid_q;
endmodule

// File: tb/tb_md_unit_param.sv
// tb/tb_md_unit_param.sv - self-checking bench for md_unit_param (reference model plus directed vectors)
module tb_md_unit_param;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  md_unit_param_if #(.WIDTH(W)) bus ();

  md_unit_param #(.WIDTH(W), .MUL_CYCLES(5), .DIV_CYCLES(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic void cmp(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: result computed arithmetically at acceptance, released after the latency.
  logic [31:0] m_hi, m_lo;
  bit          m_busy, m_done, m_dz, m_inv;
  int          m_left;
  logic [63:0] m_res;

  function automatic logic [63:0] ref_result(logic [3:0] op, logic [31:0] a, logic [31:0] b,
                                             logic [63:0] acc);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      4'd1:  return 64'(sa * sb);
      4'd2:  return ua * ub;
      4'd3: begin
        q = sa / sb;
        r = sa % sb;
        return {32'(r), 32'(q)};
      end
      4'd4:  return {a % b, a / b};
      4'd7:  return acc + 64'(sa * sb);
      4'd8:  return acc + ua * ub;
      4'd9:  return acc - 64'(sa * sb);
      default: return acc - ua * ub;
    endcase
  endfunction

  always @(posedge clk) begin
    m_done = 1'b0;
    m_dz   = 1'b0;
    m_inv  = 1'b0;
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_left = 0;
    end else if (m_busy) begin
      if (bus.cancel) begin
        m_busy = 1'b0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_res;
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (!bus.cancel && bus.op != 4'd0) begin
      if (bus.op >= 4'd11) m_inv = 1'b1;
      else if (bus.op == 4'd5) m_hi = bus.dh;
      else if (bus.op == 4'd6) m_lo = bus.dh;
      else if ((bus.op == 4'd3 || bus.op == 4'd4) && bus.dl == 0) m_dz = 1'b1;
      else begin
        m_res  = ref_result(bus.op, bus.dh, bus.dl, {m_hi, m_lo});
        m_left = (bus.op == 4'd3 || bus.op == 4'd4) ? 32 : 5;
        m_busy = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("busy", 64'(bus.busy), 64'(m_busy));
      cmp("hi", 64'(bus.hi), 64'(m_hi));
      cmp("lo", 64'(bus.lo), 64'(m_lo));
      cmp("done", 64'(bus.done), 64'(m_done));
      cmp("div_zero", 64'(bus.div_zero), 64'(m_dz));
      cmp("invalid", 64'(bus.invalid), 64'(m_inv));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle, then count busy cycles (bounded).
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     output int n);
    bus.op = op; bus.dh = a; bus.dl = b;
    tick();
    bus.op = 4'd0;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t extra[6];

  int n;
  logic [31:0] hold_hi, hold_lo;

  initial begin
    bus.op = 4'd0; bus.dh = '0; bus.dl = '0; bus.cancel = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
    cmp("reset_hi", 64'(bus.hi), 64'h0);
    cmp("reset_lo", 64'(bus.lo), 64'h0);
    cmp("reset_busy", 64'(bus.busy), 64'h0);

    // MULT with a DIVU presented during busy; the DIVU must be ignored.
    bus.op = 4'd1; bus.dh = 32'hFFFF_FFFE; bus.dl = 32'd3;
    tick();
    bus.op = 4'd4; bus.dh = 32'd100; bus.dl = 32'd7;
    tick();
    bus.op = 4'd0;
    n = 1;
    while (bus.busy && n < 100) begin n++; tick(); end
    cmp("mult_busy_len", 64'(n), 64'd5);
    cmp("mult_done", 64'(bus.done), 64'h1);
    cmp("mult_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    cmp("mult_lo", 64'(bus.lo), 64'hFFFF_FFFA);

    run(4'd2, 32'hFFFF_FFFE, 32'd3, n);
    cmp("multu_hi", 64'(bus.hi), 64'h0000_0002);
    cmp("multu_lo", 64'(bus.lo), 64'hFFFF_FFFA);

    run(4'd3, 32'hFFFF_FFF9, 32'd2, n);
    cmp("div_busy_len", 64'(n), 64'd32);
    cmp("div_done", 64'(bus.done), 64'h1);
    cmp("div_lo", 64'(bus.lo), 64'hFFFF_FFFD);
    cmp("div_hi", 64'(bus.hi), 64'hFFFF_FFFF);

    run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    cmp("div_ovf_lo", 64'(bus.lo), 64'h8000_0000);
    cmp("div_ovf_hi", 64'(bus.hi), 64'h0);

    run(4'd4, 32'd100, 32'd7, n);
    cmp("divu_lo", 64'(bus.lo), 64'd14);
    cmp("divu_hi", 64'(bus.hi), 64'd2);

    run(4'd5, 32'h0, 32'h0, n);
    cmp("mthi_busy", 64'(n), 64'd0);
    cmp("mthi_hi", 64'(bus.hi), 64'h0);
    run(4'd6, 32'hFFFF_FFFF, 32'h0, n);
    cmp("mtlo_lo", 64'(bus.lo), 64'hFFFF_FFFF);
    cmp("mtlo_done", 64'(bus.done), 64'h0);
    run(4'd7, 32'd1, 32'd1, n);
    cmp("madd_hi", 64'(bus.hi), 64'h1);
    cmp("madd_lo", 64'(bus.lo), 64'h0);

    run(4'd5, 32'h0, 32'h0, n);
    run(4'd6, 32'h0, 32'h0, n);
    run(4'd10, 32'd1, 32'd1, n);
    cmp("msubu_hi", 64'(bus.hi), 64'hFFFF_FFFF);
    cmp("msubu_lo", 64'(bus.lo), 64'hFFFF_FFFF);

    // Cancel in the third busy cycle of a MULT.
    run(4'd5, 32'h1234, 32'h0, n);
    run(4'd6, 32'h5678, 32'h0, n);
    hold_hi = bus.hi; hold_lo = bus.lo;
    bus.op = 4'd1; bus.dh = 32'd7; bus.dl = 32'd9;
    tick();
    bus.op = 4'd0;
    tick();
    tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    cmp("cancel_busy", 64'(bus.busy), 64'h0);
    cmp("cancel_hi", 64'(bus.hi), 64'(hold_hi));
    cmp("cancel_lo", 64'(bus.lo), 64'(hold_lo));
    for (int i = 0; i < 6; i++) begin
      tick();
      cmp("cancel_no_done", 64'(bus.done), 64'h0);
    end

    // Cancel with a DIV presented while idle blocks acceptance.
    bus.op = 4'd3; bus.dh = 32'd50; bus.dl = 32'd5; bus.cancel = 1'b1;
    tick();
    bus.op = 4'd0; bus.cancel = 1'b0;
    cmp("cancel_idle_busy", 64'(bus.busy), 64'h0);

    // Divide by zero.
    run(4'd3, 32'd77, 32'd0, n);
    cmp("dz_pulse", 64'(bus.div_zero), 64'h1);
    cmp("dz_busy", 64'(n), 64'd0);
    cmp("dz_hi", 64'(bus.hi), 64'(hold_hi));
    tick();
    cmp("dz_clear", 64'(bus.div_zero), 64'h0);

    // Invalid op code.
    run(4'd12, 32'd1, 32'd1, n);
    cmp("invalid_pulse", 64'(bus.invalid), 64'h1);
    tick();
    cmp("invalid_clear", 64'(bus.invalid), 64'h0);

    // Extra vectors, checked by the model only.
    extra[0] = '{4'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    extra[1] = '{4'd9,  32'hFFFF_FFFD, 32'd4};
    extra[2] = '{4'd3,  32'd7,         32'hFFFF_FFFE};
    extra[3] = '{4'd3,  32'hFFFF_FF9C, 32'hFFFF_FFF9};
    extra[4] = '{4'd4,  32'hFFFF_FFFF, 32'd1};
    extra[5] = '{4'd7,  32'h8000_0000, 32'h8000_0000};
    foreach (extra[i]) run(extra[i].op, extra[i].a, extra[i].b, n);

    // Reset during busy cycle 10 of a DIV.
    bus.op = 4'd3; bus.dh = 32'd1000; bus.dl = 32'd3;
    tick();
    bus.op = 4'd0;
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp("rst_mid_hi", 64'(bus.hi), 64'h0);
    cmp("rst_mid_lo", 64'(bus.lo), 64'h0);
    cmp("rst_mid_busy", 64'(bus.busy), 64'h0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
